// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 4-stage pipeline front end. It looks
// at the instruction in IF/ID and the instruction in EX, and decides each
// cycle whether to hold the PC and IF/ID, inject a NOP into IF/ID, or bubble
// ID/EX. It handles load-use stalls, taken-branch flushes and multi-cycle MUL
// occupancy of EX. It also keeps saturating stall and flush statistics.
//
// Ports
//   clk           in   rising-edge system clock
//   reset         in   asynchronous, active-low reset
//   id_opcode     in   [3:0] opcode held in IF/ID
//   id_src_a      in   [3:0] first source register in IF/ID
//   id_src_b      in   [3:0] second source register in IF/ID
//   ex_opcode     in   [3:0] opcode of the instruction in EX
//   ex_dest       in   [3:0] destination register of the instruction in EX
//   branch_taken  in   EX resolved a taken branch this cycle
//   pc_hold       out  PC must not advance this cycle
//   ifid_hold     out  IF/ID keeps its contents
//   ifid_nop      out  fetch mux forces opcode 4'b0000 into IF/ID
//   idex_bubble   out  ID/EX loads a NOP instead of the decoded instruction
//   busy          out  the FSM is in MULTI (EX owned by a MUL)
//   stall_count   out  [15:0] cycles with ifid_hold=1, saturating
//   flush_count   out  [15:0] taken-branch flushes, saturating
//   dbg_state     out  raw FSM state bit (0=RUN, 1=MULTI), not reset-gated
//
// There is no valid/ready handshake in this block. Every control output is
// a same-cycle combinational function of the registered state and the
// current inputs. The state and statistics advance on posedge clk.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter logic [3:0] LOAD_OP      = 4'b1000,
  parameter logic [3:0] MUL_OP       = 4'b0111,
  parameter int         MULTI_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_opcode,
  input  logic [3:0]  id_src_a,
  input  logic [3:0]  id_src_b,
  input  logic [3:0]  ex_opcode,
  input  logic [3:0]  ex_dest,
  input  logic        branch_taken,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_nop,
  output logic        idex_bubble,
  output logic        busy,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count,
  output logic        dbg_state
);

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } state_t;

  // Counter preload on MUL issue. The issue cycle itself is not held, so
  // MULTI lasts MULTI_CYCLES-1 cycles.
  localparam logic [3:0] MUL_LOAD = 4'(MULTI_CYCLES - 1);

  state_t     state;
  logic [3:0] mul_cnt;

  logic load_use;
  logic mul_issue;

  // Register 0 is hard-wired, so a load into r0 never creates a dependency.
  assign load_use = (ex_opcode == LOAD_OP) && (ex_dest != 4'd0) &&
                    ((ex_dest == id_src_a) || (ex_dest == id_src_b));

  // A MUL only issues when neither a flush nor a load-use stall takes
  // priority in the same cycle.
  assign mul_issue = (state == RUN) && !branch_taken && !load_use &&
                     (id_opcode == MUL_OP);

  assign dbg_state = (state == MULTI);

  // Control outputs. Gating with reset forces them low for the whole time
  // reset is held, even though the state register is already RUN.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_nop    = 1'b0;
    idex_bubble = 1'b0;
    busy        = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            ifid_nop    = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MULTI: begin
          // EX is owned by the MUL. Branch and load-use inputs are ignored.
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          busy        = 1'b1;
        end
        default: begin
          pc_hold = 1'b0;
        end
      endcase
    end
  end

  // FSM: RUN <-> MULTI with an occupancy down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (mul_issue) begin
            state   <= MULTI;
            mul_cnt <= MUL_LOAD;
          end
        end
        MULTI: begin
          if (mul_cnt == 4'd1) begin
            state   <= RUN;
            mul_cnt <= 4'd0;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: begin
          state   <= RUN;
          mul_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Saturating statistics. A flush only counts while in RUN, because a
  // branch seen during MULTI is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (ifid_hold && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if ((state == RUN) && branch_taken && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. A reference model tracks
// only "MUL hold cycles remaining" plus the expected statistics. Expected
// outputs come from the hazard priority rules applied to the current inputs.
// Inputs are driven 1 time unit after posedge. Outputs are sampled on
// negedge, and counters are sampled 1 time unit after posedge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] LOAD_OP = 4'b1000;
  localparam logic [3:0] MUL_OP  = 4'b0111;
  localparam int         MC      = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_opcode, id_src_a, id_src_b, ex_opcode, ex_dest;
  logic        branch_taken;
  logic        pc_hold, ifid_hold, ifid_nop, idex_bubble, busy, dbg_state;
  logic [15:0] stall_count, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int mul_rem   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .LOAD_OP(LOAD_OP), .MUL_OP(MUL_OP), .MULTI_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .ex_opcode(ex_opcode), .ex_dest(ex_dest), .branch_taken(branch_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_nop(ifid_nop),
    .idex_bubble(idex_bubble), .busy(busy),
    .stall_count(stall_count), .flush_count(flush_count),
    .dbg_state(dbg_state)
  );

  task automatic drive(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] exop,
                       input logic [3:0] exd, input logic br);
    id_opcode    = op;
    id_src_a     = a;
    id_src_b     = b;
    ex_opcode    = exop;
    ex_dest      = exd;
    branch_taken = br;
  endtask

  // One clock cycle with the inputs already driven. Checks the outputs,
  // advances the model and checks the counters.
  task automatic step(input string tag);
    logic [5:0] e_out;
    logic [5:0] got;
    logic       lu;
    lu = (ex_opcode == LOAD_OP) && (ex_dest != 4'd0) &&
         ((ex_dest == id_src_a) || (ex_dest == id_src_b));
    // {pc_hold, ifid_hold, ifid_nop, idex_bubble, busy, dbg_state}
    if (mul_rem > 0)       e_out = 6'b110111;
    else if (branch_taken) e_out = 6'b001100;
    else if (lu)           e_out = 6'b110100;
    else                   e_out = 6'b000000;
    @(negedge clk);
    got = {pc_hold, ifid_hold, ifid_nop, idex_bubble, busy, dbg_state};
    n_tests++;
    if (got !== e_out) begin
      n_fail++;
      $display("FAIL %s outputs got=%b exp=%b", tag, got, e_out);
    end
    @(posedge clk);
    if (e_out[4]) exp_stall = (exp_stall < 65535) ? exp_stall + 1 : 65535;
    if (mul_rem == 0 && branch_taken)
      exp_flush = (exp_flush < 65535) ? exp_flush + 1 : 65535;
    if (mul_rem > 0) mul_rem--;
    else if (!branch_taken && !lu && id_opcode == MUL_OP) mul_rem = MC - 1;
    #1;
    n_tests++;
    if (stall_count !== 16'(exp_stall) || flush_count !== 16'(exp_flush)) begin
      n_fail++;
      $display("FAIL %s counts got stall=%0d flush=%0d exp stall=%0d flush=%0d",
               tag, stall_count, flush_count, exp_stall, exp_flush);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_tests++;
    if ({pc_hold, ifid_hold, ifid_nop, idex_bubble, busy} !== 5'b0 ||
        stall_count !== 16'd0 || flush_count !== 16'd0) begin
      n_fail++;
      $display("FAIL %s got outs=%b stall=%0d flush=%0d exp outs=00000 stall=0 flush=0",
               tag, {pc_hold, ifid_hold, ifid_nop, idex_bubble, busy},
               stall_count, flush_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(4'd0, 4'd3, 4'd3, LOAD_OP, 4'd3, 1'b1);
    #2;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_after_edge");
    reset = 1'b1;
    mul_rem = 0; exp_stall = 0; exp_flush = 0;
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("idle_after_reset");
  endtask

  task automatic test_load_use();
    drive(4'd1, 4'd2, 4'd3, LOAD_OP, 4'd3, 1'b0);
    step("load_use_src_b");
    n_tests++;
    if (stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_stall1 got=%0d exp=1", stall_count);
    end
    drive(4'd1, 4'd2, 4'd0, LOAD_OP, 4'd0, 1'b0);
    step("load_r0_no_stall");
    drive(4'd1, 4'd2, 4'd3, LOAD_OP, 4'd5, 1'b0);
    step("load_r5_no_stall");
    drive(4'd1, 4'd9, 4'd1, LOAD_OP, 4'd9, 1'b0);
    step("load_use_src_a");
  endtask

  task automatic test_branch();
    int s0;
    s0 = exp_stall;
    drive(4'd1, 4'd2, 4'd3, LOAD_OP, 4'd3, 1'b1);
    step("branch_over_load_use");
    n_tests++;
    if (stall_count !== 16'(s0)) begin
      n_fail++;
      $display("FAIL branch_stall_unchanged got=%0d exp=%0d", stall_count, s0);
    end
  endtask

  task automatic test_mul();
    logic [15:0] s0, f0;
    s0 = stall_count;
    f0 = flush_count;
    drive(MUL_OP, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    step("mul_issue");
    drive(4'd1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < MC - 1; i++) step("mul_multi");
    step("mul_back_to_run");
    n_tests++;
    if (stall_count - s0 !== 16'd3 || flush_count !== f0) begin
      n_fail++;
      $display("FAIL mul_stall_delta got=%0d exp=3", stall_count - s0);
    end
  endtask

  task automatic test_mul_ignores_hazards();
    logic [15:0] f0;
    f0 = flush_count;
    drive(MUL_OP, 4'd4, 4'd4, 4'd0, 4'd0, 1'b0);
    step("mul2_issue");
    drive(4'd1, 4'd4, 4'd4, LOAD_OP, 4'd4, 1'b1);
    step("mul2_branch_ignored");
    drive(4'd1, 4'd4, 4'd4, LOAD_OP, 4'd4, 1'b0);
    step("mul2_load_use_ignored");
    drive(4'd1, 4'd4, 4'd4, 4'd0, 4'd0, 1'b1);
    step("mul2_branch_ignored2");
    drive(4'd1, 4'd4, 4'd4, 4'd0, 4'd0, 1'b0);
    step("mul2_back_to_run");
    n_tests++;
    if (flush_count !== f0) begin
      n_fail++;
      $display("FAIL mul2_flush_unchanged got=%0d exp=%0d", flush_count, f0);
    end
  endtask

  task automatic test_reset_mid_multi();
    logic [15:0] s0;
    drive(MUL_OP, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    step("mul3_issue");
    drive(4'd1, 4'd1, 4'd2, LOAD_OP, 4'd1, 1'b1);
    step("mul3_multi1");
    // Second MULTI cycle: reset arrives between clock edges.
    #1;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mul3_busy_before_reset got=%b exp=1", busy);
    end
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_multi");
    mul_rem = 0; exp_stall = 0; exp_flush = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("after_reset_run");
    s0 = stall_count;
    drive(MUL_OP, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
    step("mul4_issue");
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < MC; i++) step("mul4_seq");
    n_tests++;
    if (stall_count - s0 !== 16'd3) begin
      n_fail++;
      $display("FAIL mul4_stall_delta got=%0d exp=3", stall_count - s0);
    end
  endtask

  task automatic test_random();
    logic [3:0] op, exop;
    for (int i = 0; i < 400; i++) begin
      op   = ($urandom_range(0, 3) == 0) ? MUL_OP : 4'($urandom_range(0, 15));
      exop = ($urandom_range(0, 2) == 0) ? LOAD_OP : 4'($urandom_range(0, 15));
      drive(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), exop,
            4'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      step("random");
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_mul_ignores_hazards();
    test_reset_mid_multi();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
